ps2_key_decoder: RTL and testbench

//   Parametrised PS/2 set-2 scancode-to-ASCII decoder with a buffered stream output.

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_scan_lut.sv | 80 ++++++++
 rtl/ps2_key_decoder.sv | 182 ++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 set-2 scancode decoder.
//   - Prefix and modifier scancode constants
//   - Parse-state enum used by the prefix FSM
//   - Helpers: protocol/status bytes to ignore, ASCII letter test
package ps2_pkg;

    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_BRK  = 8'hF0;
    localparam logic [7:0] SC_LSH  = 8'h12;
    localparam logic [7:0] SC_RSH  = 8'h59;
    localparam logic [7:0] SC_CTL  = 8'h14;
    localparam logic [7:0] SC_CAPS = 8'h58;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } parse_state_t;

    // Keyboard status/response bytes and the Pause prefix carry no key event.
    function automatic logic is_ignored(input logic [7:0] b);
        case (b)
            8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFE, 8'h00, 8'hFF: is_ignored = 1'b1;
            default:                                                is_ignored = 1'b0;
        endcase
    endfunction

    function automatic logic is_letter(input logic [7:0] ch);
        is_letter = (ch >= 8'h61 && ch <= 8'h7A) || (ch >= 8'h41 && ch <= 8'h5A);
    endfunction

endpackage

// File: rtl/ps2_scan_lut.sv
// Combinational set-2 scancode to ASCII lookup.
// Ports:
//   sc     in  8  scancode (prefix already stripped)
//   ext    in  1  key arrived with the E0 prefix
//   shift  in  1  shift state (selects upper symbol on non-letter keys)
//   caps   in  1  caps-lock state (letters use shift ^ caps)
//   ascii  out 8  character, 0 when the key has no printable mapping
module ps2_scan_lut (
    input  logic [7:0] sc,
    input  logic       ext,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii
);

    logic [7:0] letter;
    logic [7:0] sym;

    always_comb begin
        letter = 8'h00;
        case (sc)
            8'h1C: letter = "a";  8'h32: letter = "b";  8'h21: letter = "c";
            8'h23: letter = "d";  8'h24: letter = "e";  8'h2B: letter = "f";
            8'h34: letter = "g";  8'h33: letter = "h";  8'h43: letter = "i";
            8'h3B: letter = "j";  8'h42: letter = "k";  8'h4B: letter = "l";
            8'h3A: letter = "m";  8'h31: letter = "n";  8'h44: letter = "o";
            8'h4D: letter = "p";  8'h15: letter = "q";  8'h2D: letter = "r";
            8'h1B: letter = "s";  8'h2C: letter = "t";  8'h3C: letter = "u";
            8'h2A: letter = "v";  8'h1D: letter = "w";  8'h22: letter = "x";
            8'h35: letter = "y";  8'h1A: letter = "z";
            default: letter = 8'h00;
        endcase
    end

    always_comb begin
        sym = 8'h00;
        case (sc)
            8'h16: sym = shift ? "!" : "1";
            8'h1E: sym = shift ? "@" : "2";
            8'h26: sym = shift ? "#" : "3";
            8'h25: sym = shift ? "$" : "4";
            8'h2E: sym = shift ? "%" : "5";
            8'h36: sym = shift ? "^" : "6";
            8'h3D: sym = shift ? "&" : "7";
            8'h3E: sym = shift ? "*" : "8";
            8'h46: sym = shift ? "(" : "9";
            8'h45: sym = shift ? ")" : "0";
            8'h0E: sym = shift ? "~" : 8'h60;
            8'h4E: sym = shift ? "_" : "-";
            8'h55: sym = shift ? "+" : "=";
            8'h54: sym = shift ? "{" : "[";
            8'h5B: sym = shift ? "}" : "]";
            8'h5D: sym = shift ? "|" : "\\";
            8'h4C: sym = shift ? ":" : ";";
            8'h52: sym = shift ? "\"" : "'";
            8'h41: sym = shift ? "<" : ",";
            8'h49: sym = shift ? ">" : ".";
            8'h4A: sym = shift ? "?" : "/";
            8'h29: sym = 8'h20;
            8'h5A: sym = 8'h0D;
            8'h66: sym = 8'h08;
            8'h0D: sym = 8'h09;
            8'h76: sym = 8'h1B;
            default: sym = 8'h00;
        endcase
    end

    always_comb begin
        ascii = 8'h00;
        if (ext) begin
            if (sc == 8'h4A)      ascii = "/";
            else if (sc == 8'h5A) ascii = 8'h0D;
        end else if (letter != 8'h00) begin
            ascii = (shift ^ caps) ? (letter - 8'h20) : letter;
        end else begin
            ascii = sym;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scancode to ASCII decoder with a first-word-fall-through output FIFO.
// Parses E0/F0 prefixes, tracks Shift/Ctrl/CapsLock, suppresses typematic repeats.
//
//   state   | meaning
//   --------+------------------------------------------
//   IDLE    | waiting for a prefix or a make code
//   EXT     | E0 seen; next byte is an extended make or F0
//   BRK     | F0 seen; next byte is a normal break
//   EXT_BRK | E0 F0 seen; next byte is an extended break
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   sc, sc_valid          scancode byte and its one-cycle strobe
//   ascii_data/valid      FIFO head and non-empty flag
//   ascii_ready           consumer pops the head when valid && ready
//   fifo_count            occupied FIFO entries
//   overflow/overflow_clr sticky drop flag and its synchronous clear
//   mods                  {caps_lock, ctrl, shift}
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int REPEAT_EN  = 0,
    parameter int CTRL_EN    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    sc,
    input  logic                          sc_valid,
    output logic [7:0]                    ascii_data,
    output logic                          ascii_valid,
    input  logic                          ascii_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic [2:0]                    mods
);

    localparam int AW = $clog2(FIFO_DEPTH);

    parse_state_t state, state_nxt;
    logic         is_make, is_break, key_ext;
    logic         lsh, rsh, lctl, rctl, caps, caps_held;
    logic [7:0]   last_make;
    logic         m_lsh, m_rsh, m_lctl, m_rctl, m_caps, is_mod;
    logic [7:0]   lut_ch, ch;
    logic         emit;
    logic         emit_q;
    logic [7:0]   ch_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        is_make   = 1'b0;
        is_break  = 1'b0;
        key_ext   = 1'b0;
        if (sc_valid) begin
            case (state)
                IDLE: begin
                    if (sc == SC_EXT)        state_nxt = EXT;
                    else if (sc == SC_BRK)   state_nxt = BRK;
                    else if (!is_ignored(sc)) is_make  = 1'b1;
                end
                EXT: begin
                    if (sc == SC_BRK) begin
                        state_nxt = EXT_BRK;
                    end else begin
                        is_make   = 1'b1;
                        key_ext   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                BRK: begin
                    is_break  = 1'b1;
                    state_nxt = IDLE;
                end
                EXT_BRK: begin
                    is_break  = 1'b1;
                    key_ext   = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign m_lsh  = !key_ext && (sc == SC_LSH);
    assign m_rsh  = !key_ext && (sc == SC_RSH);
    assign m_lctl = !key_ext && (sc == SC_CTL);
    assign m_rctl =  key_ext && (sc == SC_CTL);
    assign m_caps = !key_ext && (sc == SC_CAPS);
    assign is_mod = m_lsh | m_rsh | m_lctl | m_rctl | m_caps;

    ps2_scan_lut u_lut (
        .sc    (sc),
        .ext   (key_ext),
        .shift (lsh | rsh),
        .caps  (caps),
        .ascii (lut_ch)
    );

    assign ch = ((CTRL_EN != 0) && (lctl | rctl) && is_letter(lut_ch)) ? (lut_ch & 8'h1F) : lut_ch;

    assign emit = is_make && !is_mod && (ch != 8'h00) && ((REPEAT_EN != 0) || (sc != last_make));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lsh       <= 1'b0;
            rsh       <= 1'b0;
            lctl      <= 1'b0;
            rctl      <= 1'b0;
            caps      <= 1'b0;
            caps_held <= 1'b0;
            last_make <= 8'h00;
        end else if (is_make) begin
            if (m_lsh)  lsh  <= 1'b1;
            if (m_rsh)  rsh  <= 1'b1;
            if (m_lctl) lctl <= 1'b1;
            if (m_rctl) rctl <= 1'b1;
            // Typematic repeats of CapsLock must not re-toggle until it is released.
            if (m_caps && !caps_held) begin
                caps      <= ~caps;
                caps_held <= 1'b1;
            end
            if (!is_mod) last_make <= sc;
        end else if (is_break) begin
            if (m_lsh)  lsh       <= 1'b0;
            if (m_rsh)  rsh       <= 1'b0;
            if (m_lctl) lctl      <= 1'b0;
            if (m_rctl) rctl      <= 1'b0;
            if (m_caps) caps_held <= 1'b0;
            if (sc == last_make) last_make <= 8'h00;
        end
    end

    // One pipeline stage so the character appears on the edge after the final byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            emit_q <= 1'b0;
            ch_q   <= 8'h00;
        end else begin
            emit_q <= emit;
            ch_q   <= ch;
        end
    end

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, pop, push;

    assign fifo_count = wr_ptr - rd_ptr;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (fifo_count == (AW+1)'(FIFO_DEPTH));
    assign pop        = !empty && ascii_ready;
    assign push       = emit_q && (!full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= ch_q;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (emit_q && full && !pop) overflow <= 1'b1;
            else if (overflow_clr)      overflow <= 1'b0;
        end
    end

    assign ascii_data  = mem[rd_ptr[AW-1:0]];
    assign ascii_valid = !empty;
    assign mods        = {caps, lctl | rctl, lsh | rsh};

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sc;
    logic       sc_valid;
    logic [7:0] ascii_data;
    logic       ascii_valid;
    logic       ascii_ready;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       overflow_clr;
    logic [2:0] mods;

    logic [7:0] sc2;
    logic       sc_valid2;
    logic [7:0] data2;
    logic       valid2;
    logic       ready2;
    logic [3:0] count2;
    logic       ovf2;
    logic [2:0] mods2;

    always #5 clk = ~clk;

    ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .REPEAT_EN(0), .CTRL_EN(1)) dut (
        .clk(clk), .reset(reset), .sc(sc), .sc_valid(sc_valid),
        .ascii_data(ascii_data), .ascii_valid(ascii_valid), .ascii_ready(ascii_ready),
        .fifo_count(fifo_count), .overflow(overflow), .overflow_clr(overflow_clr), .mods(mods)
    );

    ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .REPEAT_EN(1), .CTRL_EN(1)) dut_rep (
        .clk(clk), .reset(reset), .sc(sc2), .sc_valid(sc_valid2),
        .ascii_data(data2), .ascii_valid(valid2), .ascii_ready(ready2),
        .fifo_count(count2), .overflow(ovf2), .overflow_clr(1'b0), .mods(mods2)
    );

    typedef struct {
        logic [31:0] b;
        int          n;
        logic [7:0]  exp;
        logic [2:0]  mods;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] exp_q[$];
    int         n_vec  = 0;
    int         n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Scoreboard: every handshake must match the oldest expected character.
    always @(negedge clk) begin
        if (!reset && ascii_valid && ascii_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_char: got %0h, expected none", ascii_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (ascii_data !== e) begin
                    n_miss++;
                    $display("FAIL char_order: got %0h, expected %0h", ascii_data, e);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        sc = b;
        sc_valid = 1'b1;
        @(posedge clk);
        #1;
        sc_valid = 1'b0;
    endtask

    task automatic send_byte2(input logic [7:0] b);
        sc2 = b;
        sc_valid2 = 1'b1;
        @(posedge clk);
        #1;
        sc_valid2 = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 60) begin
            @(posedge clk);
            i++;
        end
        #1;
        chk(name, exp_q.size(), 0);
    endtask

    task automatic add(input logic [31:0] b, input int n, input logic [7:0] e, input logic [2:0] m);
        vec_t v;
        v.b = b; v.n = n; v.exp = e; v.mods = m;
        tbl.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        sc = 8'h00; sc_valid = 1'b0; ascii_ready = 1'b0; overflow_clr = 1'b0;
        sc2 = 8'h00; sc_valid2 = 1'b0; ready2 = 1'b0;
        reset = 1'b1;

        //   bytes (left first)                 n  char   {caps,ctrl,shift}
        add({8'h12, 8'h1C, 8'hF0, 8'h1C}, 4, 8'h41, 3'b001);
        add({8'hF0, 8'h12, 16'h0},        2, 8'h00, 3'b000);
        add({8'h58, 8'hF0, 8'h58, 8'h0},  3, 8'h00, 3'b100);
        add({8'h1C, 8'hF0, 8'h1C, 8'h0},  3, 8'h41, 3'b100);
        add({8'h12, 8'h1C, 8'hF0, 8'h1C}, 4, 8'h61, 3'b101);
        add({8'hF0, 8'h12, 16'h0},        2, 8'h00, 3'b100);
        add({8'h58, 8'hF0, 8'h58, 8'h0},  3, 8'h00, 3'b000);
        add({8'h16, 8'hF0, 8'h16, 8'h0},  3, 8'h31, 3'b000);
        add({8'h12, 8'h16, 8'hF0, 8'h16}, 4, 8'h21, 3'b001);
        add({8'hF0, 8'h12, 16'h0},        2, 8'h00, 3'b000);
        add({8'h14, 8'h21, 8'hF0, 8'h21}, 4, 8'h03, 3'b010);
        add({8'hF0, 8'h14, 16'h0},        2, 8'h00, 3'b000);
        add({8'hE0, 8'h14, 8'h21, 8'h0},  3, 8'h03, 3'b010);
        add({8'hF0, 8'h21, 16'h0},        2, 8'h00, 3'b010);
        add({8'hE0, 8'hF0, 8'h14, 8'h0},  3, 8'h00, 3'b000);
        add({8'hE0, 8'h5A, 16'h0},        2, 8'h0D, 3'b000);
        add({8'hE0, 8'hF0, 8'h5A, 8'h0},  3, 8'h00, 3'b000);
        add({8'hE0, 8'h75, 16'h0},        2, 8'h00, 3'b000);
        add({8'hE0, 8'hF0, 8'h75, 8'h0},  3, 8'h00, 3'b000);
        add({8'hE0, 8'h4A, 16'h0},        2, 8'h2F, 3'b000);
        add({8'hE0, 8'hF0, 8'h4A, 8'h0},  3, 8'h00, 3'b000);
        add({8'h29, 8'hF0, 8'h29, 8'h0},  3, 8'h20, 3'b000);
        add({8'h66, 8'hF0, 8'h66, 8'h0},  3, 8'h08, 3'b000);
        add({8'h0D, 8'hF0, 8'h0D, 8'h0},  3, 8'h09, 3'b000);
        add({8'h76, 8'hF0, 8'h76, 8'h0},  3, 8'h1B, 3'b000);
        add({8'h12, 8'h52, 8'hF0, 8'h52}, 4, 8'h22, 3'b001);
        add({8'hF0, 8'h12, 16'h0},        2, 8'h00, 3'b000);
        add({8'hAA, 8'hFA, 16'h0},        2, 8'h00, 3'b000);
        add({8'h1C, 8'h1C, 8'h1C, 8'h1C}, 4, 8'h61, 3'b000);
        add({8'h1C, 8'hF0, 8'h1C, 8'h0},  3, 8'h00, 3'b000);
        add({8'h58, 8'h58, 8'h58, 8'hF0}, 4, 8'h00, 3'b100);
        add({8'h58, 24'h0},               1, 8'h00, 3'b100);
        add({8'h1C, 8'hF0, 8'h1C, 8'h0},  3, 8'h41, 3'b100);
        add({8'h58, 8'hF0, 8'h58, 8'h0},  3, 8'h00, 3'b000);
        add({8'h1C, 8'hF0, 8'h1C, 8'h0},  3, 8'h61, 3'b000);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", ascii_valid, 0);
        chk("rst_data", ascii_data, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_mods", mods, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // First character: one-cycle latency, no output on the break.
        exp_q.push_back(8'h61);
        send_byte(8'h1C);
        chk("latency_early", ascii_valid, 0);
        @(posedge clk);
        #1;
        chk("latency_valid", ascii_valid, 1);
        chk("latency_data", ascii_data, 8'h61);
        send_byte(8'hF0);
        send_byte(8'h1C);
        repeat (2) @(posedge clk);
        #1;
        chk("single_count", fifo_count, 1);
        ascii_ready = 1'b1;
        wait_drain("single_drain");
        chk("single_empty", fifo_count, 0);

        foreach (tbl[i]) begin
            if (tbl[i].exp != 8'h00) exp_q.push_back(tbl[i].exp);
            for (int k = 0; k < tbl[i].n; k++) send_byte(tbl[i].b[8*(3-k) +: 8]);
            repeat (2) @(posedge clk);
            wait_drain($sformatf("row%0d_drain", i));
            chk($sformatf("row%0d_mods", i), mods, tbl[i].mods);
        end

        // Overflow: DEPTH+1 distinct keys with the consumer stalled.
        ascii_ready = 1'b0;
        begin
            logic [7:0] keys [9];
            logic [7:0] chars[9];
            keys  = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
            chars = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};
            for (int k = 0; k < 9; k++) begin
                if (k < DEPTH) exp_q.push_back(chars[k]);
                send_byte(keys[k]);
                send_byte(8'hF0);
                send_byte(keys[k]);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        chk("full_count", fifo_count, DEPTH);
        chk("full_overflow", overflow, 1);
        chk("full_head", ascii_data, 8'h61);

        // Push and pop in the same cycle while full.
        sc = 8'h3B;
        sc_valid = 1'b1;
        @(posedge clk);
        #1;
        sc_valid = 1'b0;
        ascii_ready = 1'b1;
        exp_q.push_back(8'h6A);
        @(posedge clk);
        #1;
        ascii_ready = 1'b0;
        chk("pushpop_count", fifo_count, DEPTH);
        chk("pushpop_head", ascii_data, 8'h62);
        send_byte(8'hF0);
        send_byte(8'h3B);

        overflow_clr = 1'b1;
        @(posedge clk);
        #1;
        overflow_clr = 1'b0;
        chk("ovf_clear", overflow, 0);

        // A drop in the same cycle as the clear keeps the flag set.
        sc = 8'h42;
        sc_valid = 1'b1;
        @(posedge clk);
        #1;
        sc_valid = 1'b0;
        overflow_clr = 1'b1;
        @(posedge clk);
        #1;
        overflow_clr = 1'b0;
        chk("ovf_set_wins", overflow, 1);
        chk("ovf_drop_count", fifo_count, DEPTH);
        send_byte(8'hF0);
        send_byte(8'h42);

        ascii_ready = 1'b1;
        wait_drain("full_drain");
        chk("full_drain_empty", fifo_count, 0);

        // Reset in the middle of an E0 F0 prefix.
        send_byte(8'hE0);
        send_byte(8'hF0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_mods", mods, 0);
        chk("midrst_count", fifo_count, 0);
        exp_q.push_back(8'h61);
        send_byte(8'h1C);
        wait_drain("midrst_make");
        send_byte(8'hF0);
        send_byte(8'h1C);
        repeat (3) @(posedge clk);
        #1;
        chk("final_empty", ascii_valid, 0);

        // Repeat-enabled instance: every typematic make emits.
        for (int k = 0; k < 5; k++) send_byte2(8'h1C);
        send_byte2(8'hF0);
        send_byte2(8'h1C);
        repeat (2) @(posedge clk);
        #1;
        chk("rep_count", count2, 5);
        chk("rep_head", data2, 8'h61);
        chk("rep_overflow", ovf2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
